// File: rtl/pcs_tx_pkg.sv
// Shared encodings for the 1000BASE-X PCS transmit ordered-set generator:
// code-group octets, xmit modes, FSM states and the IPG counter width.
package pcs_tx_pkg;

    localparam int IPG_W = 4;

    localparam logic [7:0] CG_K28_5 = 8'hBC;
    localparam logic [7:0] CG_D21_5 = 8'hB5;
    localparam logic [7:0] CG_D2_2  = 8'h42;
    localparam logic [7:0] CG_D5_6  = 8'hC5;
    localparam logic [7:0] CG_D16_2 = 8'h50;

    localparam logic [7:0] CG_S = 8'hFB;
    localparam logic [7:0] CG_T = 8'hFD;
    localparam logic [7:0] CG_R = 8'hF7;
    localparam logic [7:0] CG_V = 8'hFE;

    typedef enum logic [1:0] {
        XM_CONFIG   = 2'b00,
        XM_IDLE     = 2'b01,
        XM_DATA     = 2'b10,
        XM_IDLE_ALT = 2'b11
    } xmit_t;

    typedef enum logic [2:0] {
        TX_TEST_XMIT,
        CFG_SEQ,
        IDLE_K,
        XMIT_DATA,
        TX_DATA,
        EPD_R1,
        EPD_R2,
        EXTEND
    } tx_state_t;

endpackage

// File: rtl/pcs_tx_ordered_set_gen.sv
// 1000BASE-X PCS transmit ordered-set generator: GMII TXD/TX_EN/TX_ER to one code group per clock.
// Define PCS_TX_CARRIER_EXT_EN to add the carrier-extension (EXTEND) state.
//
// state        | meaning
// TX_TEST_XMIT | after reset or a /V/ abort; picks the mode at the next even boundary
// CFG_SEQ      | sending /C1/ or /C2/ sets, cfg_cnt = index of the last octet sent
// IDLE_K       | sending /I/ sets in IDLE mode
// XMIT_DATA    | sending /I/ sets in DATA mode, waiting for TX_EN and IPG
// TX_DATA      | inside a packet (/S/ already sent)
// EPD_R1       | first /R/ after /T/
// EPD_R2       | second /R/ to realign to an even boundary
// EXTEND       | carrier extension, /R/ (or /V/) per cycle while TX_ER is high
module pcs_tx_ordered_set_gen
    import pcs_tx_pkg::*;
#(
    parameter int IPG_MIN_IDLES = 1,
    parameter bit CFG_ALT       = 1'b1
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic [1:0]  xmit,
    input  logic        TX_EN,
    input  logic        TX_ER,
    input  logic [7:0]  TXD,
    input  logic [15:0] tx_config_reg,
    input  logic        tx_disparity,
    output logic [7:0]  tx_cg_data,
    output logic        tx_cg_k,
    output logic        tx_even,
    output logic        transmitting
);

    localparam logic [IPG_W-1:0] IPG_RELOAD = IPG_W'(IPG_MIN_IDLES);

    tx_state_t        state;
    tx_state_t        state_nxt;
    xmit_t            xm;
    logic [IPG_W-1:0] ipg_cnt;
    logic [IPG_W-1:0] ipg_nxt;
    logic [1:0]       cfg_cnt;
    logic [1:0]       cfg_cnt_nxt;
    logic [15:0]      cfg_word;
    logic [15:0]      cfg_word_nxt;
    logic             cfg_c2;
    logic             cfg_c2_nxt;
    logic [7:0]       cg_nxt;
    logic             k_nxt;
    logic             tr_nxt;
    logic             bnd;
    logic             set_edge;
    logic             start_ok;
    logic             abort;
    logic             ext_req;

    assign xm       = xmit_t'(xmit);
    // The code group registered on this edge lands in an even slot.
    assign bnd      = ~tx_even;
    assign start_ok = (xm == XM_DATA) && TX_EN && (ipg_cnt == '0);
    assign abort    = bnd && (xm != XM_DATA);

`ifdef PCS_TX_CARRIER_EXT_EN
    localparam logic [7:0] EXT_OCTET = 8'h0F;
    assign ext_req = !TX_EN && TX_ER && (TXD == EXT_OCTET);
`else
    assign ext_req = 1'b0;
`endif

    always_comb begin
        set_edge = 1'b0;
        case (state)
            TX_TEST_XMIT, IDLE_K, XMIT_DATA: set_edge = bnd;
            CFG_SEQ:                         set_edge = (cfg_cnt == 2'd3);
            default:                         set_edge = 1'b0;
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) state <= TX_TEST_XMIT;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_TEST_XMIT, IDLE_K, XMIT_DATA, CFG_SEQ: begin
                if (set_edge) begin
                    if (xm == XM_CONFIG)    state_nxt = CFG_SEQ;
                    else if (xm == XM_DATA) state_nxt = start_ok ? TX_DATA : XMIT_DATA;
                    else                    state_nxt = IDLE_K;
                end
            end
            TX_DATA: begin
                if (abort)       state_nxt = TX_TEST_XMIT;
                else if (!TX_EN) state_nxt = ext_req ? EXTEND : EPD_R1;
            end
            EPD_R1:  state_nxt = ext_req ? EXTEND : (bnd ? EPD_R2 : XMIT_DATA);
            EPD_R2:  state_nxt = XMIT_DATA;
`ifdef PCS_TX_CARRIER_EXT_EN
            EXTEND:  if (!TX_ER) state_nxt = bnd ? EPD_R2 : XMIT_DATA;
`endif
            default: state_nxt = TX_TEST_XMIT;
        endcase
    end

    always_comb begin
        cg_nxt       = CG_K28_5;
        k_nxt        = 1'b1;
        tr_nxt       = 1'b0;
        ipg_nxt      = ipg_cnt;
        cfg_cnt_nxt  = cfg_cnt;
        cfg_word_nxt = cfg_word;
        cfg_c2_nxt   = cfg_c2;
        case (state)
            TX_TEST_XMIT, IDLE_K, XMIT_DATA, CFG_SEQ: begin
                if (set_edge) begin
                    if (xm == XM_CONFIG) begin
                        cfg_cnt_nxt  = 2'd0;
                        cfg_word_nxt = tx_config_reg;
                        cfg_c2_nxt   = (state == CFG_SEQ) && CFG_ALT && !cfg_c2;
                    end else begin
                        cfg_c2_nxt = 1'b0;
                        if (start_ok) begin
                            cg_nxt = CG_S;
                            tr_nxt = 1'b1;
                        end
                    end
                end else if (state == CFG_SEQ) begin
                    k_nxt       = 1'b0;
                    cfg_cnt_nxt = cfg_cnt + 2'd1;
                    case (cfg_cnt)
                        2'd0:    cg_nxt = cfg_c2 ? CG_D2_2 : CG_D21_5;
                        2'd1:    cg_nxt = cfg_word[7:0];
                        default: cg_nxt = cfg_word[15:8];
                    endcase
                end else begin
                    // Second half of /I/; the filler after a /V/ abort does not count toward IPG.
                    k_nxt  = 1'b0;
                    cg_nxt = tx_disparity ? CG_D5_6 : CG_D16_2;
                    if (state != TX_TEST_XMIT && ipg_cnt != '0) ipg_nxt = ipg_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                tr_nxt = 1'b1;
                if (abort) begin
                    cg_nxt = CG_V;
                    tr_nxt = 1'b0;
                end else if (!TX_EN) begin
                    cg_nxt = CG_T;
                end else if (TX_ER) begin
                    cg_nxt = CG_V;
                end else begin
                    cg_nxt = TXD;
                    k_nxt  = 1'b0;
                end
            end
            EPD_R1: begin
                cg_nxt = CG_R;
                tr_nxt = 1'b1;
                if (!ext_req && !bnd) ipg_nxt = IPG_RELOAD;
            end
            EPD_R2: begin
                cg_nxt  = CG_R;
                tr_nxt  = 1'b1;
                ipg_nxt = IPG_RELOAD;
            end
`ifdef PCS_TX_CARRIER_EXT_EN
            EXTEND: begin
                tr_nxt = 1'b1;
                if (TX_ER) begin
                    cg_nxt = (TXD == EXT_OCTET) ? CG_R : CG_V;
                end else begin
                    cg_nxt = CG_R;
                    if (!bnd) ipg_nxt = IPG_RELOAD;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            tx_cg_data   <= CG_K28_5;
            tx_cg_k      <= 1'b1;
            tx_even      <= 1'b0;
            transmitting <= 1'b0;
            ipg_cnt      <= IPG_RELOAD;
            cfg_cnt      <= 2'd0;
            cfg_word     <= 16'h0000;
            cfg_c2       <= 1'b0;
        end else begin
            tx_cg_data   <= cg_nxt;
            tx_cg_k      <= k_nxt;
            tx_even      <= ~tx_even;
            transmitting <= tr_nxt;
            ipg_cnt      <= ipg_nxt;
            cfg_cnt      <= cfg_cnt_nxt;
            cfg_word     <= cfg_word_nxt;
            cfg_c2       <= cfg_c2_nxt;
        end
    end

endmodule

// File: tb/tb_pcs_tx_ordered_set_gen.sv
// Bench for pcs_tx_ordered_set_gen: directed sequences plus randomized GMII traffic,
// checked every cycle against an ordered-set level reference model.
module tb_pcs_tx_ordered_set_gen;

    localparam int IPG_MIN = 2;
    localparam bit ALT     = 1'b1;

    localparam int PH_SETS = 0;
    localparam int PH_PKT  = 1;
    localparam int PH_EPD  = 2;
    localparam int PH_EXT  = 3;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       tr;
        logic       oi;
        logic       cnt;
    } ent_t;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic [1:0]  xmit;
    logic        tx_en;
    logic        tx_er;
    logic [7:0]  txd;
    logic [15:0] tx_config_reg;
    logic        tx_disparity;
    logic [7:0]  tx_cg_data;
    logic        tx_cg_k;
    logic        tx_even;
    logic        transmitting;

    int n_chk = 0;
    int n_err = 0;

    ent_t       q[$];
    int         ph;
    int         idles;
    bit         c2_next;
    bit         m_even;
    logic [7:0] e_d;
    logic       e_k;
    logic       e_tr;
    logic       e_even;

    int fr_left  = 0;
    int gap_left = 3;
    int ext_left = 0;

    logic [7:0] cfg_exp  [8]  = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01};
    logic [7:0] fa_txd   [5]  = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB};
    logic [7:0] fa_exp   [9]  = '{8'hFB, 8'h55, 8'hD5, 8'hAA, 8'hBB, 8'hFD, 8'hF7, 8'hF7, 8'hBC};
    logic [7:0] fb_txd   [5]  = '{8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
    logic [7:0] fb_exp   [13] = '{8'hFB, 8'hD5, 8'h11, 8'hFE, 8'h33, 8'hFD, 8'hF7, 8'hF7,
                                  8'hBC, 8'h50, 8'hBC, 8'h50, 8'hFB};

    always #5 clk_sys = ~clk_sys;

    pcs_tx_ordered_set_gen #(
        .IPG_MIN_IDLES (IPG_MIN),
        .CFG_ALT       (ALT)
    ) dut (
        .GTX_CLK       (clk_sys),
        .mr_main_reset (rst_b),
        .xmit          (xmit),
        .TX_EN         (tx_en),
        .TX_ER         (tx_er),
        .TXD           (txd),
        .tx_config_reg (tx_config_reg),
        .tx_disparity  (tx_disparity),
        .tx_cg_data    (tx_cg_data),
        .tx_cg_k       (tx_cg_k),
        .tx_even       (tx_even),
        .transmitting  (transmitting)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [7:0] d, input logic k, input logic tr,
                                input logic oi, input logic cnt);
        ent_t e;
        e.d   = d;
        e.k   = k;
        e.tr  = tr;
        e.oi  = oi;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        ph      = PH_SETS;
        idles   = 0;
        c2_next = 1'b0;
        m_even  = 1'b1;
    endtask

    // End of packet: /R/ now, a second /R/ if this one sits in an even slot.
    task automatic model_eop();
        e_d   = 8'hF7;
        idles = 0;
        if (m_even) q.push_back(mk(8'hF7, 1'b1, 1'b1, 1'b0, 1'b0));
        ph = PH_SETS;
    endtask

    // Expected code group for the edge that consumes the current inputs.
    task automatic model_step();
        ent_t e;
        bit   ext;
        ext = 1'b0;
`ifdef PCS_TX_CARRIER_EXT_EN
        ext = !tx_en && tx_er && (txd == 8'h0F);
`endif
        e_even = m_even;
        e_k    = 1'b1;
        e_tr   = 1'b1;
        e_d    = 8'h00;
        case (ph)
            PH_SETS: begin
                if (q.size() == 0) begin
                    if (xmit == 2'b00) begin
                        q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0));
                        q.push_back(mk(c2_next ? 8'h42 : 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0));
                        q.push_back(mk(tx_config_reg[7:0], 1'b0, 1'b0, 1'b0, 1'b0));
                        q.push_back(mk(tx_config_reg[15:8], 1'b0, 1'b0, 1'b0, 1'b0));
                        c2_next = ALT ? !c2_next : 1'b0;
                    end else begin
                        c2_next = 1'b0;
                        if (xmit == 2'b10 && tx_en && idles >= IPG_MIN) begin
                            ph = PH_PKT;
                        end else begin
                            q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0));
                            q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
                        end
                    end
                end
                if (ph == PH_PKT) begin
                    e_d = 8'hFB;
                end else begin
                    e = q.pop_front();
                    if (e.oi) begin
                        e_d  = tx_disparity ? 8'hC5 : 8'h50;
                        e_k  = 1'b0;
                        e_tr = 1'b0;
                        if (e.cnt) idles++;
                    end else begin
                        e_d  = e.d;
                        e_k  = e.k;
                        e_tr = e.tr;
                    end
                end
            end
            PH_PKT: begin
                if (m_even && xmit != 2'b10) begin
                    e_d  = 8'hFE;
                    e_tr = 1'b0;
                    q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
                    ph = PH_SETS;
                end else if (tx_en) begin
                    if (tx_er) e_d = 8'hFE;
                    else begin
                        e_d = txd;
                        e_k = 1'b0;
                    end
                end else begin
                    e_d = 8'hFD;
                    ph  = ext ? PH_EXT : PH_EPD;
                end
            end
            PH_EPD: begin
                if (ext) begin
                    e_d = 8'hF7;
                    ph  = PH_EXT;
                end else begin
                    model_eop();
                end
            end
            default: begin
                if (tx_er) e_d = (txd == 8'h0F) ? 8'hF7 : 8'hFE;
                else       model_eop();
            end
        endcase
        m_even = !m_even;
    endtask

    // Inputs are already driven; one clock edge, then compare against the model.
    task automatic cycle();
        model_step();
        @(posedge clk_sys);
        #1;
        check_val("cg", {tx_cg_data, tx_cg_k, tx_even, transmitting}, {e_d, e_k, e_even, e_tr});
        @(negedge clk_sys);
    endtask

    task automatic gen_random();
        tx_disparity = 1'($urandom_range(1));
        if ($urandom_range(199) == 0) begin
            case ($urandom_range(9))
                0:       xmit = 2'b00;
                1:       xmit = 2'b01;
                2:       xmit = 2'b11;
                default: xmit = 2'b10;
            endcase
        end
        if ($urandom_range(7) == 0) tx_config_reg = 16'($urandom);
        if (fr_left == 0 && gap_left == 0) begin
            fr_left  = $urandom_range(20, 1);
            gap_left = $urandom_range(8, 1);
            ext_left = ($urandom_range(3) == 0) ? $urandom_range(4, 1) : 0;
        end
        if (fr_left > 0) begin
            tx_en = 1'b1;
            txd   = 8'($urandom);
            tx_er = ($urandom_range(15) == 0);
            fr_left--;
        end else begin
            tx_en = 1'b0;
            gap_left--;
            if (ext_left > 0) begin
                tx_er = 1'b1;
                txd   = ($urandom_range(7) == 0) ? 8'h1F : 8'h0F;
                ext_left--;
            end else begin
                tx_er = ($urandom_range(7) == 0);
                txd   = 8'($urandom);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_data"}, tx_cg_data, 8'hBC);
        check_val({tag, "_k"}, tx_cg_k, 1'b1);
        check_val({tag, "_even"}, tx_even, 1'b0);
        check_val({tag, "_tr"}, transmitting, 1'b0);
    endtask

    initial begin
        rst_b         = 1'b0;
        xmit          = 2'b01;
        tx_en         = 1'b0;
        tx_er         = 1'b0;
        txd           = 8'h00;
        tx_config_reg = 16'h0000;
        tx_disparity  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_values("reset");

        @(negedge clk_sys);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("idle_i2", {tx_cg_data, tx_cg_k}, (i % 2 == 0) ? 9'h179 : 9'h0A0);
            check_val("idle_even", tx_even, (i % 2 == 0));
        end

        cycle();
        tx_disparity = 1'b1;
        cycle();
        check_val("idle_i1", tx_cg_data, 8'hC5);
        tx_disparity = 1'b0;

        xmit          = 2'b00;
        tx_config_reg = 16'h01A0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_val("cfg_seq", tx_cg_data, cfg_exp[i]);
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 1) tx_config_reg = 16'h1234;
            if (i == 6) xmit = 2'b01;
            cycle();
        end

        xmit = 2'b10;
        for (int i = 0; i < 6; i++) cycle();
        for (int i = 0; i < 2 && !m_even; i++) cycle();
        for (int i = 0; i < 9; i++) begin
            tx_en = (i < 5);
            txd   = (i < 5) ? fa_txd[i] : 8'h00;
            cycle();
            check_val("frame_a", tx_cg_data, fa_exp[i]);
            check_val("frame_a_tr", transmitting, (i < 8));
        end
        for (int i = 0; i < 5; i++) cycle();

        for (int i = 0; i < 2 && !m_even; i++) cycle();
        for (int i = 0; i < 20; i++) begin
            tx_en = (i < 5) || (i >= 6 && i < 16);
            tx_er = (i == 3);
            txd   = (i < 5) ? fb_txd[i] : 8'(8'h60 + i);
            cycle();
            if (i < 13) check_val("frame_b2b", tx_cg_data, fb_exp[i]);
        end
        tx_er = 1'b0;

`ifdef PCS_TX_CARRIER_EXT_EN
        for (int i = 0; i < 8; i++) cycle();
        for (int i = 0; i < 2 && !m_even; i++) cycle();
        for (int i = 0; i < 11; i++) begin
            tx_en = (i < 4);
            tx_er = (i >= 4 && i < 8);
            txd   = (i < 4) ? 8'(8'h30 + i) : ((i == 6) ? 8'h1F : 8'h0F);
            cycle();
            if (i == 4) check_val("ext_t", tx_cg_data, 8'hFD);
            if (i == 5) check_val("ext_r", tx_cg_data, 8'hF7);
            if (i == 6) check_val("ext_v", tx_cg_data, 8'hFE);
            if (i == 9) check_val("ext_tr", transmitting, 1'b1);
            if (i == 10) check_val("ext_end", tx_cg_data, 8'hBC);
        end
        tx_er = 1'b0;
`endif

        for (int i = 0; i < 8; i++) cycle();
        for (int i = 0; i < 2 && !m_even; i++) cycle();
        tx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            txd = 8'(8'h80 + i);
            cycle();
        end
        check_val("mid_pkt_tr", transmitting, 1'b1);
        rst_b = 1'b0;
        #1;
        check_reset_values("mid_reset");
        tx_en = 1'b0;
        repeat (2) @(negedge clk_sys);
        model_reset();
        rst_b = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            gen_random();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pcs_tx_ordered_set_gen.md
Name: pcs_tx_ordered_set_gen

Overview:
- 1000BASE-X PCS transmit ordered-set generator. Sits between the GMII transmit side and the 8b/10b encoder.
- Converts TXD/TX_EN/TX_ER into one code group per GTX_CLK (8-bit value plus K flag).
- Handles IDLE alternation (/I1/ /I2/) by running disparity, even/odd alignment, /C1/ /C2/ configuration sets, /V/ error propagation, and minimum IPG enforcement.

Parameters:
- IPG_MIN_IDLES, 1, minimum complete /I/ sets after end-of-packet before next /S/; legal range 1..15.
- CFG_ALT, 1, 1: alternate /C1/ and /C2/; 0: send /C1/ only.

Ports:
- GTX_CLK  in  1  transmit clock, all logic on rising edge.
- mr_main_reset  in  1  asynchronous, active-low reset.
- xmit  in  2  00 CONFIGURATION, 01 IDLE, 10 DATA, 11 treated as IDLE.
- TX_EN  in  1  GMII transmit enable.
- TX_ER  in  1  GMII transmit error.
- TXD  in  8  GMII transmit data.
- tx_config_reg  in  16  config word for /C/ sets.
- tx_disparity  in  1  encoder running disparity after the last code group; 1 = positive.
- tx_cg_data  out  8  code group octet.
- tx_cg_k  out  1  1 = K code group.
- tx_even  out  1  1 = current output is an even position.
- transmitting  out  1  high from /S/ through last /R/.

Behaviour:
- Reset is asynchronous, active-low on mr_main_reset. While asserted: state TX_TEST_XMIT, tx_cg_data=0xBC, tx_cg_k=1, tx_even=0, transmitting=0, IPG counter=IPG_MIN_IDLES.
- All outputs are registered. TXD to tx_cg_data latency is 1 cycle.
- tx_even toggles every cycle unconditionally. The first cycle after reset release is even.
- Ordered-set boundary: any cycle whose output will be even. xmit is sampled only at boundaries.
- A change of xmit mid-set completes the current set first.
- Code constants:
  - K28.5=BC, D21.5=B5, D2.2=42, D5.6=C5, D16.2=50.
  - /S/=FB, /T/=FD, /R/=F7, /V/=FE (all K=1).
- TX_TEST_XMIT: at the first boundary, go to CFG_SEQ, IDLE_K or XMIT_DATA according to xmit.
- CFG_SEQ: 4-cycle set.
  - C1 = BC(K), B5, cfg[7:0], cfg[15:8].
  - C2 = BC(K), 42, cfg[7:0], cfg[15:8].
  - Alternates C1/C2 when CFG_ALT=1.
  - tx_config_reg is captured at set start; a change mid-set appears in the next set.
- Idle: even cycle BC(K). Odd cycle C5 if tx_disparity=1 (/I1/), else 50 (/I2/). Disparity is sampled in the even cycle.
  - Each completed /I/ decrements the IPG counter, saturating at 0.
- XMIT_DATA (DATA mode): at a boundary with TX_EN=1 and IPG counter=0, emit /S/ on that even cycle, replacing the octet. Set transmitting=1 and go to TX_DATA.
  - TX_EN=1 but IPG counter not yet 0: continue idling; those octets are discarded.
  - TX_EN rising on an odd cycle: the second idle code group completes; that octet is discarded.
- TX_DATA: each cycle:
  - TX_EN=1, TX_ER=0: emit TXD with K=0.
  - TX_EN=1, TX_ER=1: emit /V/.
  - TX_EN=0: emit /T/ and go to EPD_R1.
- EPD_R1: emit /R/.
  - If the next cycle is even, go to idle and reload the IPG counter.
  - Otherwise go to EPD_R2: emit /R/, then go to idle and reload.
  - transmitting drops in the cycle after the last /R/.
- xmit leaves DATA mid-packet: at the next boundary emit /V/ once, then enter the new mode. No /T/ is sent. transmitting drops with the /V/.
- TX_ER while TX_EN=0 is ignored (base build).
- Reset mid-packet: immediate return to reset values; no /T/ is sent.

Optional Feature:
- PCS_TX_CARRIER_EXT_EN defined:
  - At the /T/ cycle and in EPD_R1, if TX_EN=0, TX_ER=1 and TXD=0x0F: emit /R/ (carrier extension), stay in state EXTEND, and keep transmitting=1.
  - In EXTEND, TX_ER=1 with TXD!=0x0F emits /V/.
  - Extension ends when TX_ER=0, then goes through the EPD_R1/R2 rules.
- Undefined: no EXTEND state; TX_ER with TX_EN=0 is ignored.

Decomposition:
- Package pcs_tx_pkg:
  - code-group constants listed above;
  - xmit enum;
  - state enum;
  - 4-bit IPG counter width.
- No sub-module. The CFG word counter and IPG counter are inline.

Test Plan:
- Reset release, xmit=01, tx_disparity=0: outputs BC(K),50,BC(K),50; tx_even 1,0,1,0.
- Idle with tx_disparity=1 during the even cycle: odd output is C5.
- xmit=00, cfg=0x01A0, CFG_ALT=1: outputs BC,B5,A0,01,BC,42,A0,01 repeating.
- xmit=10, frame 55,55,D5,AA,BB with TX_EN rising on an even boundary:
  - output FB,55,D5,AA,BB,FD,F7 then [F7 if odd], then idle;
  - transmitting high from FB through last F7.
- TX_ER=1 on data octet 3 -> FE in that slot. Back-to-back frame with IPG_MIN_IDLES=2 -> /S/ only after 2 full /I/ sets.
- PCS_TX_CARRIER_EXT_EN: after TX_EN drops, TX_ER=1 TXD=0F for 3 cycles -> FD, F7,F7,F7, then R/R alignment; TXD=1F during extension -> FE.
